aes192_loop_feeder: RTL and testbench
=====================================

AES192_LOOP_FEEDER -- requirements
Module: aes192_loop_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning block/beat width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, meaning buffer entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter CNT_W, default 32, meaning block-counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 ap_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 ap_rst_n  in  1  synchronous active-low reset.
REQ-007 cfg_start  in  1  job start pulse; honoured only in IDLE.
REQ-008 num_blocks  in  CNT_W  job length; latched when cfg_start is honoured.
REQ-009 s_tdata / s_tvalid / s_tlast  in  DATA_W/1/1  input plaintext stream.
REQ-010 s_tready  out  1  input accept.
REQ-011 loop_ap_start  out  1  start to the encrypt loop flow-control stage.
REQ-012 loop_data / loop_last  out  DATA_W/1  block and final-block flag presented with loop_ap_start.
REQ-013 loop_ap_ready  in  1  loop has consumed the presented block.
REQ-014 loop_ap_done  in  1  one loop run has completed.
REQ-015 busy / done / err_len / blocks_done  out  1/1/1/CNT_W  status outputs.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN and FIN.
REQ-017 IDLE + cfg_start SHALL latch num_blocks, clear all counters and err_len, and go to RUN, or to FIN when num_blocks==0.
REQ-018 In RUN, s_tready SHALL be !full; a beat is accepted on s_tvalid&s_tready and pushed into the FIFO.
REQ-019 An accept counter SHALL count accepted beats; when the beat making it equal num_blocks is accepted, the FSM SHALL go to DRAIN, and s_tready SHALL be 0 in DRAIN, FIN and IDLE.
REQ-020 loop_ap_start SHALL equal FIFO non-empty (RUN or DRAIN); loop_data SHALL be the FIFO head with zero-cycle latency.
REQ-021 Pop SHALL occur on loop_ap_start&loop_ap_ready; loop_data and loop_ap_start SHALL hold stable until pop.
REQ-022 Same-cycle push and pop SHALL be legal at any occupancy below full, leaving occupancy unchanged; a push when full is impossible (ready low).
REQ-023 loop_last SHALL be 1 exactly for the num_blocks-th issued block.
REQ-024 blocks_done SHALL increment on each loop_ap_done in RUN/DRAIN and saturate at all-ones; loop_ap_done in IDLE/FIN is ignored.
REQ-025 DRAIN SHALL go to FIN when the FIFO is empty and blocks_done==num_blocks.
REQ-026 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 err_len SHALL set (sticky until the next honoured cfg_start) when s_tlast=1 on an accepted beat other than the last expected one, or s_tlast=0 on the last expected one.
REQ-028 busy SHALL be 1 in RUN, DRAIN and FIN.
REQ-029 cfg_start in any state other than IDLE SHALL be ignored.

Reset
REQ-030 When ap_rst_n=0 at a clock edge: FSM=IDLE, FIFO empty, counters=0, and all outputs 0 (s_tready, loop_ap_start, loop_last, busy, done, err_len, blocks_done), including mid-job; no partial job resumes.

Configuration
REQ-031 With AES192_FEEDER_STATS_EN defined, an extra output stall_cycles (CNT_W) SHALL count cycles with loop_ap_start=1 and loop_ap_ready=0, saturating, cleared on honoured cfg_start and on reset.
REQ-032 Without AES192_FEEDER_STATS_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package aes192_feeder_pkg SHALL hold the FSM state enum and the default DATA_W, DEPTH and CNT_W constants.
REQ-034 The FIFO SHALL be sub-module aes192_feeder_fifo (DATA_W+1 wide, DEPTH entries, show-ahead, full/empty flags).

Verification
REQ-035 num_blocks=4, 4 back-to-back beats (last with tlast), loop_ap_ready=1, done 2 cycles after each start -> 4 starts, loop_last on the 4th, blocks_done=4, one-cycle done, err_len=0.
REQ-036 DEPTH=2, loop_ap_ready held 0 for 10 cycles -> s_tready falls after 2 accepts, loop_data stable; with STATS_EN, stall_cycles=10.
REQ-037 cfg_start with num_blocks=0 -> FIN next cycle, done pulse, no loop_ap_start.
REQ-038 num_blocks=3 with tlast on beat 2 -> err_len=1 remains set; job still completes after 3 loop_ap_done.
REQ-039 ap_rst_n low during DRAIN with 1 entry queued -> next cycle all outputs 0, FSM IDLE; a new cfg_start runs cleanly.
REQ-040 cfg_start pulsed during RUN -> ignored; latched num_blocks and counters unchanged.

Source files
------------

// File: rtl/aes192_feeder_pkg.sv
// aes192_feeder_pkg
// Shared definitions for the AES-192 loop feeder:
//   - feeder_state_e : job sequencing states (IDLE, RUN, DRAIN, FIN)
//   - FEEDER_DATA_W  : default block/beat width in bits
//   - FEEDER_DEPTH   : default number of buffer entries
//   - FEEDER_CNT_W   : default block-counter width
//   - feeder_depth_ok: true when a buffer depth is a power of two in 2..16

package aes192_feeder_pkg;

    localparam int FEEDER_DATA_W = 128;
    localparam int FEEDER_DEPTH  = 2;
    localparam int FEEDER_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } feeder_state_e;

    function automatic logic feeder_depth_ok(input int depth);
        return (depth == 2) || (depth == 4) || (depth == 8) || (depth == 16);
    endfunction

endpackage

// File: rtl/aes192_feeder_fifo.sv
// aes192_feeder_fifo
// Show-ahead FIFO between the plaintext stream and the encrypt loop.
// The head entry is visible on rdata_o without a read cycle, so the
// consumer sees a new block in the same cycle it becomes the head.
// Ports:
//   clk_i    : clock, all state changes on the rising edge
//   rst_ni   : synchronous active-low reset (empties the FIFO)
//   push_i   : write wdata_i (ignored when full)
//   wdata_i  : entry to write
//   pop_i    : drop the head entry (ignored when empty)
//   rdata_o  : current head entry
//   full_o   : all DEPTH entries occupied
//   empty_o  : no entries occupied

module aes192_feeder_fifo
    import aes192_feeder_pkg::*;
#(
    parameter int WIDTH = FEEDER_DATA_W + 1,
    parameter int DEPTH = FEEDER_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one wrap bit so full and empty are distinguishable
    // when the index bits match.
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for push and pop; both may happen in one cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful while not empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/aes192_loop_feeder.sv
// aes192_loop_feeder
// Buffers a job of num_blocks plaintext beats and presents them one at a
// time to the AES-192 encrypt loop using an ap_start/ap_ready handshake.
// Tracks loop completions and reports job status.
//
// Optional feature macro: AES192_FEEDER_STATS_EN adds the stall_cycles
// output (cycles where a block was offered but not taken).
//
// Ports:
//   ap_clk, ap_rst_n        : clock and synchronous active-low reset
//   cfg_start, num_blocks   : job start pulse and job length (IDLE only)
//   s_tdata/s_tvalid/s_tlast: plaintext input stream, s_tready accept
//   loop_ap_start           : a block is offered to the loop
//   loop_data, loop_last    : offered block and final-block flag
//   loop_ap_ready           : loop has taken the offered block
//   loop_ap_done            : loop finished one block
//   busy, done, err_len     : job active, one-cycle completion, length error
//   blocks_done             : completed loop runs (saturating)
//   stall_cycles            : (stats build only) stalled offer cycles

module aes192_loop_feeder
    import aes192_feeder_pkg::*;
#(
    parameter int DATA_W = FEEDER_DATA_W,
    parameter int DEPTH  = FEEDER_DEPTH,
    parameter int CNT_W  = FEEDER_CNT_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              loop_ap_start,
    output logic [DATA_W-1:0] loop_data,
    output logic              loop_last,
    input  logic              loop_ap_ready,
    input  logic              loop_ap_done,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [CNT_W-1:0]  blocks_done
`ifdef AES192_FEEDER_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Elaboration-time guard on the buffer depth.
    if (!feeder_depth_ok(DEPTH)) begin : g_bad_depth
        $error("aes192_loop_feeder: DEPTH must be a power of two from 2 to 16");
    end

    feeder_state_e    state_q;
    feeder_state_e    state_d;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] num_d;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    logic [CNT_W-1:0] bdone_q;
    logic [CNT_W-1:0] bdone_d;
    logic             err_q;
    logic             err_d;

    logic              start_ok_s;
    logic              active_s;
    logic              accept_s;
    logic              last_beat_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W:0]   fifo_wdata_s;
    logic [DATA_W:0]   fifo_rdata_s;

    assign start_ok_s  = (state_q == ST_IDLE) && cfg_start;
    assign active_s    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign s_tready    = (state_q == ST_RUN) && !fifo_full_s;
    assign accept_s    = s_tvalid && s_tready;
    // The beat being accepted now is the final one of the job.
    assign last_beat_s = ((acc_q + CNT_ONE) == num_q);

    // The final-block flag travels with the data through the FIFO, so
    // loop_last follows the block count rather than the stream's tlast.
    assign fifo_wdata_s  = {last_beat_s, s_tdata};
    assign loop_ap_start = active_s && !fifo_empty_s;
    assign pop_s         = loop_ap_start && loop_ap_ready;
    assign loop_data     = loop_ap_start ? fifo_rdata_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign loop_last     = loop_ap_start && fifo_rdata_s[DATA_W];

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign err_len     = err_q;
    assign blocks_done = bdone_q;

    aes192_feeder_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .push_i  (accept_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Job sequencing next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = (num_blocks == {CNT_W{1'b0}}) ? ST_FIN : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_beat_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s && (bdone_q == num_q)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Job length, accept/completion counters and the sticky length error.
    always_comb begin
        num_d   = num_q;
        acc_d   = acc_q;
        bdone_d = bdone_q;
        err_d   = err_q;
        if (start_ok_s) begin
            num_d   = num_blocks;
            acc_d   = {CNT_W{1'b0}};
            bdone_d = {CNT_W{1'b0}};
            err_d   = 1'b0;
        end else begin
            if (accept_s) begin
                acc_d = acc_q + CNT_ONE;
                // tlast must appear on the final beat and nowhere else.
                if (s_tlast != last_beat_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end else begin
                acc_d = acc_q;
                err_d = err_q;
            end
            if (active_s && loop_ap_done && (bdone_q != CNT_MAX)) begin
                bdone_d = bdone_q + CNT_ONE;
            end else begin
                bdone_d = bdone_q;
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            num_q   <= {CNT_W{1'b0}};
            acc_q   <= {CNT_W{1'b0}};
            bdone_q <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            bdone_q <= bdone_d;
            err_q   <= err_d;
        end
    end

`ifdef AES192_FEEDER_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    assign stall_cycles = stall_q;

    // Stall counter: block offered but not taken this cycle.
    always_comb begin
        stall_d = stall_q;
        if (start_ok_s) begin
            stall_d = {CNT_W{1'b0}};
        end else if (loop_ap_start && !loop_ap_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            stall_q <= {CNT_W{1'b0}};
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_aes192_loop_feeder.sv
// Testbench for aes192_loop_feeder: scoreboard of issued blocks, a loop
// model that raises loop_ap_done two cycles after each taken block, and
// directed plus randomized jobs.

module tb_aes192_loop_feeder;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 32;

    logic              ap_clk        = 1'b0;
    logic              ap_rst_n      = 1'b0;
    logic              cfg_start     = 1'b0;
    logic [CNT_W-1:0]  num_blocks    = '0;
    logic [DATA_W-1:0] s_tdata       = '0;
    logic              s_tvalid      = 1'b0;
    logic              s_tlast       = 1'b0;
    logic              s_tready;
    logic              loop_ap_start;
    logic [DATA_W-1:0] loop_data;
    logic              loop_last;
    logic              loop_ap_ready = 1'b0;
    logic              loop_ap_done  = 1'b0;
    logic              busy;
    logic              done;
    logic              err_len;
    logic [CNT_W-1:0]  blocks_done;
`ifdef AES192_FEEDER_STATS_EN
    logic [CNT_W-1:0]  stall_cycles;
`endif

    aes192_loop_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .cfg_start     (cfg_start),
        .num_blocks    (num_blocks),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .loop_ap_start (loop_ap_start),
        .loop_data     (loop_data),
        .loop_last     (loop_last),
        .loop_ap_ready (loop_ap_ready),
        .loop_ap_done  (loop_ap_done),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .blocks_done   (blocks_done)
`ifdef AES192_FEEDER_STATS_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    // Stream driver / scoreboard state
    logic [DATA_W:0] drv_q[$];
    logic [DATA_W:0] exp_q[$];
    int  acc_cnt   = 0;
    int  extra_acc = 0;
    int  pops      = 0;
    bit  overdrive = 1'b0;
    bit  gap_en    = 1'b0;
    bit  drv_junk  = 1'b0;
    bit  drv_taken = 1'b0;
    bit  pop_seen  = 1'b0;
    bit  dpipe     = 1'b0;
    int  ready_mode = 2;

    // Per-job expectations
    int  job_num = 0;
    bit  job_err = 1'b0;
    int  acc0 = 0;
    int  pops0 = 0;
    int  extra0 = 0;

    // Monitor state
    bit              prev_vld = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic            prev_last = 1'b0;
    logic [DATA_W:0] mon_e;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_loop_ap_start"}, loop_ap_start, 0);
        check({tag, "_loop_last"}, loop_last, 0);
        check({tag, "_loop_data"}, loop_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_len"}, err_len, 0);
        check({tag, "_blocks_done"}, blocks_done, 0);
`ifdef AES192_FEEDER_STATS_EN
        check({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
    endtask

    // Loop ready policy: 0 always ready, 1 random, 2 never ready.
    always @(posedge ap_clk) begin
        #1;
        case (ready_mode)
            0:       loop_ap_ready = 1'b1;
            1:       loop_ap_ready = 1'($urandom_range(0, 1));
            default: loop_ap_ready = 1'b0;
        endcase
    end

    // Loop model: one loop_ap_done per taken block, two cycles later.
    always @(posedge ap_clk) begin
        #1;
        loop_ap_done = dpipe;
        dpipe = pop_seen;
    end

    // Stream driver: presents queued beats, optionally with gaps; with
    // overdrive set it keeps offering junk so any late accept is caught.
    initial begin
        forever begin
            @(negedge ap_clk);
            drv_taken = s_tvalid && s_tready && ap_rst_n;
            @(posedge ap_clk);
            #1;
            if (drv_taken) begin
                if (drv_junk) begin
                    extra_acc++;
                end else begin
                    void'(drv_q.pop_front());
                    acc_cnt++;
                end
                s_tvalid = 1'b0;
                drv_junk = 1'b0;
            end
            if (s_tvalid && drv_junk && (!overdrive || drv_q.size() > 0)) begin
                s_tvalid = 1'b0;
                drv_junk = 1'b0;
            end
            if (!s_tvalid) begin
                if (drv_q.size() > 0) begin
                    if (!gap_en || $urandom_range(0, 3) != 0) begin
                        {s_tlast, s_tdata} = drv_q[0];
                        s_tvalid = 1'b1;
                    end
                end else if (overdrive) begin
                    s_tdata  = {$urandom, $urandom, $urandom, $urandom};
                    s_tlast  = 1'b0;
                    s_tvalid = 1'b1;
                    drv_junk = 1'b1;
                end
            end
        end
    end

    // Monitor: scoreboard compare on each taken block, and hold check
    // on an offered block that was not taken.
    always @(negedge ap_clk) begin
        pop_seen = 1'b0;
        if (!ap_rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (prev_vld) begin
                check("hold_start", loop_ap_start, 1);
                check("hold_data", loop_data, prev_data);
                check("hold_last", loop_last, prev_last);
            end
            if (loop_ap_start && loop_ap_ready) begin
                pop_seen = 1'b1;
                pops++;
                check("block_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("loop_data", loop_data, mon_e[DATA_W-1:0]);
                    check("loop_last", loop_last, mon_e[DATA_W]);
                end
                prev_vld = 1'b0;
            end else begin
                prev_vld  = loop_ap_start;
                prev_data = loop_data;
                prev_last = loop_last;
            end
        end
    end

    // Build a job: expected blocks are the beats in order, with the
    // final-block flag on beat num-1 regardless of the stream's tlast.
    task automatic setup_job(input int num, input int err_idx, input int rmode, input bit gaps);
        logic [DATA_W-1:0] d;
        bit lm;
        bit tl;
        ready_mode = rmode;
        gap_en     = gaps;
        acc0       = acc_cnt;
        pops0      = pops;
        extra0     = extra_acc;
        job_num    = num;
        job_err    = 1'b0;
        for (int i = 0; i < num; i++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            lm = (i == num - 1);
            tl = lm;
            if (i == err_idx) tl = !tl;
            if (tl != lm) job_err = 1'b1;
            drv_q.push_back({tl, d});
            exp_q.push_back({lm, d});
        end
        cfg_start  = 1'b1;
        num_blocks = CNT_W'(num);
        @(posedge ap_clk);
        #1;
        cfg_start  = 1'b0;
        num_blocks = $urandom;
        overdrive  = 1'b1;
    endtask

    task automatic wait_job(input bit poke, input int exp_stall);
        int cyc;
        bit found;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 3000) begin
            @(negedge ap_clk);
            cyc++;
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (poke && cyc == 3) begin
                cfg_start  = 1'b1;
                num_blocks = 1;
            end
            if (poke && cyc == 4) cfg_start = 1'b0;
            if (done) found = 1'b1;
        end
        cfg_start = 1'b0;
        check("done_seen", found, 1);
        if (job_num == 0) check("fin_latency", cyc, 1);
        check("fin_blocks_done", blocks_done, job_num);
        check("fin_err_len", err_len, job_err);
        check("fin_busy", busy, 1);
        check("fin_loop_start", loop_ap_start, 0);
        check("fin_s_tready", s_tready, 0);
`ifdef AES192_FEEDER_STATS_EN
        if (exp_stall >= 0) check("stall_cycles", stall_cycles, exp_stall);
`else
        if (exp_stall < -1) check("stall_arg", exp_stall, -1);
`endif
        @(negedge ap_clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("err_len_sticky", err_len, job_err);
        overdrive = 1'b0;
        check("accepts", acc_cnt - acc0, job_num);
        check("pops", pops - pops0, job_num);
        check("extra_accepts", extra_acc - extra0, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] held;
        int w;
        int n;
        int e;

        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check_reset_outputs("por");
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Four back-to-back beats, loop always ready.
        setup_job(4, -1, 0, 1'b0);
        wait_job(1'b0, -1);

        // Empty job.
        setup_job(0, -1, 0, 1'b0);
        wait_job(1'b0, -1);

        // Loop stalled for ten cycles with a two-entry buffer.
        setup_job(4, -1, 2, 1'b0);
        w = 0;
        @(negedge ap_clk);
        while (!loop_ap_start && w < 20) begin
            @(negedge ap_clk);
            w++;
        end
        check("stall_start_seen", loop_ap_start, 1);
        held = loop_data;
        repeat (9) @(negedge ap_clk);
        check("stall_tready_low", s_tready, 0);
        check("stall_accepts", acc_cnt - acc0, 2);
        check("stall_data_held", loop_data, held);
        ready_mode = 0;
        wait_job(1'b0, 10);

        // tlast on beat 2 of 3.
        setup_job(3, 1, 0, 1'b0);
        wait_job(1'b0, -1);

        // cfg_start during RUN must be ignored.
        setup_job(8, -1, 1, 1'b1);
        wait_job(1'b1, -1);

        // Reset while draining with one block queued.
        setup_job(1, -1, 2, 1'b0);
        w = 0;
        @(negedge ap_clk);
        while (!loop_ap_start && w < 20) begin
            @(negedge ap_clk);
            w++;
        end
        check("drain_entry_queued", loop_ap_start, 1);
        check("drain_busy", busy, 1);
        @(posedge ap_clk);
        #1;
        ap_rst_n  = 1'b0;
        overdrive = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        check_reset_outputs("mid_job_reset");
        @(posedge ap_clk);
        #1;
        ap_rst_n   = 1'b1;
        exp_q.delete();
        drv_q.delete();
        ready_mode = 0;
        @(posedge ap_clk);
        #1;
        setup_job(3, -1, 0, 1'b0);
        wait_job(1'b0, -1);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            n = $urandom_range(1, 12);
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            setup_job(n, e, 1, 1'($urandom_range(0, 1)));
            wait_job(1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
